mod_pow_engine: RTL
===================

# mod_pow_engine

Sequential modular exponentiation engine. It computes base^exponent mod Prime using left-to-right square-and-multiply. A one-cycle registered Barrett reduction stage turns each 44-bit product into a 22-bit residue. It is the producer that feeds that reduction stage and the consumer of its output. It sits beside the twiddle-factor generators, seeding root powers (w^k) for the FFT datapath.

## Interface
- DATA_WIDTH, 22: residue width.
- DOUBLE_DATA_WIDTH, 44: product width.
- EXP_WIDTH, 16: exponent width.
- Prime, 22'd2162623: modulus.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- base  in  DATA_WIDTH  any value 0..2^22-1; sampled with start.
- exponent  in  EXP_WIDTH  sampled with start.
- busy  out  1  high from the edge that accepts start until the edge that asserts done.
- done  out  1  single-cycle pulse; result is valid from this cycle onward.
- result  out  DATA_WIDTH  final residue; holds until the next done.

## Operation
- Reset values: busy=0, done=0, result=0, state=IDLE. Reset is async, so mid-operation reset aborts immediately and discards partial work.
- Accept (IDLE & start):
  - base_r <= (base >= Prime) ? base-Prime : base. A single subtract suffices because 2^22 < 2*Prime.
  - exp_r <= exponent; bit index <= EXP_WIDTH-1; first flag set.
- start while busy: ignored, with no queueing.
- States:
  - IDLE -> SQ on start.
  - SQ: drive reducer input a*a. a = 1 when first, else the reducer output. Clear first.
  - SQ -> MU.
  - MU: drive reducer input r*(exp_r[idx] ? base_r : 1), where r = reducer output (the square).
  - MU -> SQ with idx-1 when idx>0; MU -> FIN when idx==0.
  - FIN: reducer output holds the final value. Next edge: result <= it, done <= 1, busy <= 0, -> IDLE.
- Products are formed as a full 22x22 -> 44-bit unsigned multiply with no truncation. Both operands are always < Prime, so the reducer output is fully reduced.
- exponent==0 gives result 1, including base 0 (0^0 := 1).
- done is deasserted on the edge after it rises. start may be asserted in the same cycle done is high (state is already IDLE), and is accepted.

## Timing
- Reducer latency: exactly 1 cycle. The product driven in cycle t is readable as a residue in cycle t+1.
- Fixed-time build: done is high after edge N+2*EXP_WIDTH+1, where edge N sampled start. That is 33 edges for EXP_WIDTH=16.
- Variable-time build: done at N+EXP_WIDTH+popcount(exponent)+1.
- Back-to-back throughput: one operation per latency plus 0 idle cycles.

## Configuration
- MOD_POW_CONST_TIME_EN defined: the MU step is always executed, multiplying by 1 for zero bits. Latency is independent of exponent.
- Macro undefined:
  - MU is skipped when exp_r[idx]==0, so SQ -> SQ (or SQ -> FIN at idx 0).
  - The next SQ squares the reducer output directly.
  - Latency depends on exponent as given under Timing.

## Structure
- Shared package contents:
  - Prime, DATA_WIDTH, DOUBLE_DATA_WIDTH.
  - Barrett constants: rf_FRI=20, rf_SEC=25, pre_computing=24'd16269304.
  - State enum {IDLE, SQ, MU, FIN}.
- One sub-module: mod_pow_reduce. It is a 44 -> 22-bit Barrett stage with one registered output, async active-low reset, and the same clk/rst_n. The engine owns the FSM, operand muxes and multiplier.

## Test plan
- base=3, exponent=2 -> result 9.
  - Fixed-time build: done exactly 2*EXP_WIDTH+1 edges after start.
  - busy high throughout.
- base=2, exponent=22 -> result 2031681 (4194304-Prime).
- base=2, exponent=21 -> result 2097152.
- base=2162628 (Prime+5), exponent=2 -> result 25, confirming the accept-time reduction.
- base=0, exponent=0 -> result 1.
- base=7, exponent=0xFFFF -> result matches the golden model. start pulsed mid-run is ignored.
- Reset mid-run:
  - rst_n low during SQ -> busy=0, done=0, result=0 immediately.
  - After release, a new start (base=5, exponent=3) -> result 125.

Source files
------------

// File: rtl/mod_pow_engine_pkg.sv
// Shared constants and types for the modular exponentiation engine:
// modulus, datapath widths, Barrett reduction constants and the FSM state enum.
package mod_pow_engine_pkg;

  localparam int DATA_WIDTH        = 22;
  localparam int DOUBLE_DATA_WIDTH = 44;

  localparam logic [DATA_WIDTH-1:0] Prime = 22'd2162623;

  // Barrett constants: quotient estimate q = ((x >> rf_FRI) * pre_computing) >> rf_SEC,
  // with pre_computing = floor(2^(rf_FRI+rf_SEC) / Prime).
  localparam int          rf_FRI        = 20;
  localparam int          rf_SEC        = 25;
  localparam logic [23:0] pre_computing = 24'd16269304;

  typedef enum logic [1:0] {
    IDLE,
    SQ,
    MU,
    FIN
  } state_t;

endpackage

// File: rtl/mod_pow_reduce.sv
// One-cycle Barrett reduction: 44-bit product in, fully reduced 22-bit residue
// out on the following cycle. Inputs are products of two operands below Prime.
module mod_pow_reduce
  import mod_pow_engine_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DOUBLE_DATA_WIDTH-1:0] prod_p0,
  output logic [DATA_WIDTH-1:0]        res_p1
);

  localparam int HI_W = DOUBLE_DATA_WIDTH - rf_FRI;
  localparam int Q_W  = HI_W + 24 - rf_SEC;
  localparam int R_W  = DATA_WIDTH + 2;

  // The quotient estimate undershoots by at most two, so the remainder is
  // below 3*Prime and two conditional subtracts bring it fully into range.
  function automatic logic [DATA_WIDTH-1:0] barrett(input logic [DOUBLE_DATA_WIDTH-1:0] x);
    logic [HI_W-1:0] x_hi;
    logic [Q_W-1:0]  q;
    logic [R_W-1:0]  r;
    x_hi = x[DOUBLE_DATA_WIDTH-1:rf_FRI];
    q    = Q_W'((48'(x_hi) * 48'(pre_computing)) >> rf_SEC);
    r    = R_W'(46'(x) - 46'(q) * 46'(Prime));
    if (r >= R_W'(Prime)) r = r - R_W'(Prime);
    if (r >= R_W'(Prime)) r = r - R_W'(Prime);
    return DATA_WIDTH'(r);
  endfunction

  // p0 -> p1: register the reduced residue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_p1 <= '0;
    else        res_p1 <= barrett(prod_p0);
  end

endmodule

// File: rtl/mod_pow_engine.sv
// Left-to-right square-and-multiply modular exponentiation engine
// (base^exponent mod Prime) feeding a one-cycle Barrett reducer.
// Build option: MOD_POW_CONST_TIME_EN -- when defined, the multiply step runs
// for every exponent bit (multiplying by 1 for zero bits) so latency is fixed;
// otherwise multiply steps are skipped for zero bits.
module mod_pow_engine
  import mod_pow_engine_pkg::*;
#(
  parameter int EXP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [EXP_WIDTH-1:0]  exponent,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int IDX_W = $clog2(EXP_WIDTH);

  state_t                         state, state_nxt;
  logic                           accept, step;
  logic                           first;
  logic [IDX_W-1:0]               idx;
  logic [DATA_WIDTH-1:0]          base_r;
  logic [EXP_WIDTH-1:0]           exp_r;
  logic [DATA_WIDTH-1:0]          op_a, op_b;
  logic [DOUBLE_DATA_WIDTH-1:0]   prod_p0;
  logic [DATA_WIDTH-1:0]          red_p1;

  assign busy = (state != IDLE);

  // Next-state logic: accept in IDLE, walk exponent bits MSB first
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SQ;
          accept    = 1'b1;
        end
      end
      SQ: begin
`ifdef MOD_POW_CONST_TIME_EN
        state_nxt = MU;
`else
        if (exp_r[idx]) begin
          state_nxt = MU;
        end else if (idx == '0) begin
          state_nxt = FIN;
        end else begin
          state_nxt = SQ;
          step      = 1'b1;
        end
`endif
      end
      MU: begin
        if (idx == '0) begin
          state_nxt = FIN;
        end else begin
          state_nxt = SQ;
          step      = 1'b1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Control registers: bit index, first-square flag, done pulse and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      first  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= (state == FIN);
      if (state == FIN) result <= red_p1;
      if (accept) begin
        idx   <= IDX_W'(EXP_WIDTH - 1);
        first <= 1'b1;
      end else begin
        if (step)        idx   <= idx - 1'b1;
        if (state == SQ) first <= 1'b0;
      end
    end
  end

  // Operand capture at accept; a single subtract suffices since 2^22 < 2*Prime
  always_ff @(posedge clk) begin
    if (accept) begin
      base_r <= (base >= Prime) ? base - Prime : base;
      exp_r  <= exponent;
    end
  end

  // Operand mux: square the running value, or multiply it by base or 1
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      SQ: begin
        op_a = first ? DATA_WIDTH'(1) : red_p1;
        op_b = first ? DATA_WIDTH'(1) : red_p1;
      end
      MU: begin
        op_a = red_p1;
        op_b = exp_r[idx] ? base_r : DATA_WIDTH'(1);
      end
      default: begin
        op_a = '0;
        op_b = '0;
      end
    endcase
  end

  // p0: full-width product into the reducer
  assign prod_p0 = DOUBLE_DATA_WIDTH'(op_a) * DOUBLE_DATA_WIDTH'(op_b);

  mod_pow_reduce u_reduce (
    .clk     (clk),
    .rst_n   (rst_n),
    .prod_p0 (prod_p0),
    .res_p1  (red_p1)
  );

endmodule
